// File: rtl/jt10_adpcm_pkg.sv
// ----------------------------------------------------------------------------
// jt10_adpcm_pkg
// Shared definitions for the ADPCM sample-ROM arbiter:
//   - ADPCM_AW    : default byte-address width ({bank,addr} for ADPCM-A)
//   - arb_state_t : arbiter FSM encoding (IDLE / BUSY_A / BUSY_B)
//   - RR_A/RR_B   : values of the round-robin "last granted" bit
// ----------------------------------------------------------------------------
package jt10_adpcm_pkg;

  localparam int ADPCM_AW = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_A = 2'd1,
    ST_BUSY_B = 2'd2
  } arb_state_t;

  // rr records which requester was granted most recently.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

endpackage

// File: rtl/jt10_adpcm_rom_port.sv
// ----------------------------------------------------------------------------
// jt10_adpcm_rom_port
// Per-requester byte holder. Keeps the last fetched byte with the address it
// came from, and tells the arbiter whether a fetch is needed.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   addr_i         : requester byte address
//   roe_n_i        : requester read enable, active low
//   load_i         : memory ack for a fetch granted to this requester
//   load_addr_i    : address that was fetched (the memory-side address)
//   load_data_i    : fetched byte
//   data_o         : byte last fetched for this requester
//   pend_o         : read enabled and held byte does not match addr_i
//   ok_o           : read enabled and held byte matches addr_i
// ----------------------------------------------------------------------------
module jt10_adpcm_rom_port
  import jt10_adpcm_pkg::*;
#(
  parameter int AW = ADPCM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          roe_n_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [7:0]    load_data_i,
  output logic [7:0]    data_o,
  output logic          pend_o,
  output logic          ok_o
);

  logic [AW-1:0] tag_q;
  logic          vld_q;
  logic [7:0]    data_q;
  logic          hit;

  // The tag is taken from the memory-side address so that a requester that
  // moved on mid-fetch sees a mismatch and asks again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= 8'h00;
    end else if (load_i) begin
      tag_q  <= load_addr_i;
      vld_q  <= 1'b1;
      data_q <= load_data_i;
    end
  end

  assign hit    = vld_q && (tag_q == addr_i);
  assign pend_o = !roe_n_i && !hit;
  assign ok_o   = !roe_n_i && hit;
  assign data_o = data_q;

endmodule

// File: rtl/jt10_adpcm_rom_arb.sv
// ----------------------------------------------------------------------------
// jt10_adpcm_rom_arb
// Shares one sample-ROM port between the ADPCM-A and ADPCM-B drivers. Each
// requester keeps its last byte; a fetch is issued only when the held byte
// does not match the requested address. Ties are resolved round-robin.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   a_addr, a_roe_n         : ADPCM-A address / read enable (active low)
//   a_data, a_ok            : ADPCM-A byte and "byte matches address" flag
//   b_addr, b_roe_n         : ADPCM-B address / read enable (active low)
//   b_data, b_ok            : ADPCM-B byte and "byte matches address" flag
//   mem_addr, mem_req       : ROM fetch address and level request
//   mem_ack, mem_dout       : ROM one-cycle ack with data
//   dbg_state_o             : current arbiter state
//
// Memory handshake: mem_req is a level that rises with a stable mem_addr and
// stays high, with mem_addr unchanged, until the cycle mem_ack is sampled
// high; mem_dout is taken in that cycle and mem_req drops on the next edge.
// An ack while no request is outstanding is ignored.
// ----------------------------------------------------------------------------
module jt10_adpcm_rom_arb
  import jt10_adpcm_pkg::*;
#(
  parameter int AW = ADPCM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_roe_n,
  output logic [7:0]    a_data,
  output logic          a_ok,
  input  logic [AW-1:0] b_addr,
  input  logic          b_roe_n,
  output logic [7:0]    b_data,
  output logic          b_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output arb_state_t    dbg_state_o
);

  arb_state_t    state_q;
  logic          rr_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;

  logic pend_a, pend_b;
  logic grant_a, grant_b;
  logic load_a, load_b;

  // On a tie, the requester that was not granted last wins.
  assign grant_a = pend_a && (!pend_b || (rr_q == RR_B));
  assign grant_b = pend_b && (!pend_a || (rr_q == RR_A));

  // Only an ack for the outstanding fetch may load a requester.
  assign load_a = (state_q == ST_BUSY_A) && mem_ack;
  assign load_b = (state_q == ST_BUSY_B) && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= RR_B;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_a) begin
            state_q    <= ST_BUSY_A;
            mem_req_q  <= 1'b1;
            mem_addr_q <= a_addr;
            rr_q       <= RR_A;
          end else if (grant_b) begin
            state_q    <= ST_BUSY_B;
            mem_req_q  <= 1'b1;
            mem_addr_q <= b_addr;
            rr_q       <= RR_B;
          end
        end
        ST_BUSY_A, ST_BUSY_B: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  jt10_adpcm_rom_port #(.AW(AW)) u_port_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (a_addr),
    .roe_n_i     (a_roe_n),
    .load_i      (load_a),
    .load_addr_i (mem_addr_q),
    .load_data_i (mem_dout),
    .data_o      (a_data),
    .pend_o      (pend_a),
    .ok_o        (a_ok)
  );

  jt10_adpcm_rom_port #(.AW(AW)) u_port_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (b_addr),
    .roe_n_i     (b_roe_n),
    .load_i      (load_b),
    .load_addr_i (mem_addr_q),
    .load_data_i (mem_dout),
    .data_o      (b_data),
    .pend_o      (pend_b),
    .ok_o        (b_ok)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/jt10_adpcm_rom_arb.md
# jt10_adpcm_rom_arb

Arbitrates the single ADPCM sample-ROM port between the ADPCM-A driver and the ADPCM-B driver of the JT10 core. Each requester presents a byte address plus an output-enable; the block fetches the byte through a req/ack memory port, latches it per requester and suppresses refetches of an already-held address (ADPCM-A reads each byte twice, once per nibble). Sits between the ADPCM drivers and the system SDRAM/BRAM sample-ROM interface.

## Interface
Parameters:
- AW, 24, byte-address width on both requester and memory sides ({bank,addr} for ADPCM-A).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_addr  in  AW  ADPCM-A byte address.
- a_roe_n  in  1  ADPCM-A read enable, active low.
- a_data  out  8  byte last fetched for requester A.
- a_ok  out  1  a_data matches current a_addr and a_roe_n low.
- b_addr  in  AW  ADPCM-B byte address.
- b_roe_n  in  1  ADPCM-B read enable, active low.
- b_data  out  8  byte last fetched for requester B.
- b_ok  out  1  as a_ok, for B.
- mem_addr  out  AW  address to sample ROM.
- mem_req  out  1  fetch request, level.
- mem_ack  in  1  one-cycle pulse: mem_dout valid this cycle.
- mem_dout  in  8  ROM data.

## Operation
- Per requester x: registers x_tag (AW), x_vld, x_data. pend_x = !x_roe_n && !(x_vld && x_tag==x_addr).
- FSM states IDLE, BUSY_A, BUSY_B.
- IDLE: only pend_a -> BUSY_A; only pend_b -> BUSY_B; both -> grant the requester not granted last (rr bit; reset value rr selects A first). On entry: mem_req<=1, mem_addr<=granted x_addr, rr<=granted id.
- BUSY_x: mem_req and mem_addr held stable until mem_ack. On mem_ack: x_data<=mem_dout, x_tag<=mem_addr (the fetched address, not current x_addr), x_vld<=1, mem_req<=0, state<=IDLE.
- Requester address change during BUSY_x: fetch completes with old address; tag mismatch re-raises pend_x in IDLE; no abort.
- x_roe_n high: no new fetch; x_data, x_tag, x_vld retained (valid data reused when reads resume at same address).
- mem_ack in IDLE: ignored, no register changes.
- x_ok = !x_roe_n && x_vld && x_tag==x_addr (combinational from registers and inputs).
- Reset values: state IDLE, mem_req 0, mem_addr 0, a_data/b_data 0, x_tag 0, x_vld 0, rr=B-last (A wins first tie); hence a_ok=b_ok=0.

## Timing
- pend_x seen in IDLE at cycle n -> mem_req=1 and mem_addr valid at n+1.
- mem_ack at cycle k -> x_data/x_ok valid at k+1, mem_req low at k+1, state IDLE at k+1; next grant's mem_req earliest k+2 (one idle cycle between transactions).
- Tag hit: x_ok combinational with no memory cycle.
- Fairness: with both pending continuously, grants strictly alternate A,B,A,B.
- Reset asserted mid-transaction: mem_req drops immediately (async); an ack arriving after release lands in IDLE and is ignored.

## Structure
- Shared package jt10_adpcm_pkg: state encoding (IDLE/BUSY_A/BUSY_B) and default AW.
- One sub-module, jt10_adpcm_rom_port, instantiated twice: holds tag/vld/data, computes pend and ok, loads on a grant-qualified ack. Top holds FSM, rr bit, mem_addr/mem_req.

## Test plan
- A only: a_addr=0x012345, a_roe_n=0; ack with mem_dout=0xA5 three cycles after mem_req -> mem_addr=0x012345, a_data=0xA5, a_ok=1 the cycle after ack, mem_req low.
- Repeated read: hold a_addr=0x012345 after fetch for 20 cycles -> no further mem_req, a_ok stays 1.
- Contention: both pending continuously with fresh addresses each grant -> mem_addr sequence A,B,A,B; first grant A after reset.
- Mid-fetch change: a_addr 0x000010->0x000011 while BUSY_A, ack 0x11 -> a_tag=0x000010, a_ok=0, second mem_req for 0x000011 two cycles after first ack.
- Stray ack: mem_ack pulse in IDLE with mem_dout=0xFF -> a_data, b_data, x_vld unchanged.
- Reset mid-transaction: rst_n low during BUSY_B -> mem_req=0 immediately, b_ok=0, state IDLE; late ack after release ignored.
